// File: rtl/duck_pkg.sv
// Shared types and default constants for the duck-hunt channel controller.
// Every file that needs the channel state enum or the default limits imports this package.
package duck_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPAWN,
      ST_FLY,
      ST_FALL,
      ST_ESCAPE,
      ST_DONE
   } duck_st_e;

   localparam int DEF_X_MAX         = 1024;
   localparam int DEF_Y_GRASS       = 600;
   localparam int DEF_NOMINAL_V_SPD = 15;
   localparam int DEF_FALL_SPD      = 8;
   localparam int DEF_ESCAPE_FRAMES = 300;

endpackage

// File: rtl/ctl_duck_ch.sv
// One duck channel: spawn, bouncing flight, hit-fall and escape sequencing.
// Positions advance only on new_frame strobes; game_start restarts the channel from any state.
module ctl_duck_ch
   import duck_pkg::*;
#(
   parameter int X_MAX         = DEF_X_MAX,
   parameter int Y_GRASS       = DEF_Y_GRASS,
   parameter int NOMINAL_V_SPD = DEF_NOMINAL_V_SPD,
   parameter int FALL_SPD      = DEF_FALL_SPD,
   parameter int ESCAPE_FRAMES = DEF_ESCAPE_FRAMES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       new_frame,
   input  logic       game_start,
   input  logic       no_ammo,
   input  logic       hit,
   input  logic       spawn_dir,
   input  logic [4:0] v_spd,
   input  logic [4:0] h_spd,
   input  logic [9:0] start_x,
   output logic [9:0] duck_x,
   output logic [9:0] duck_y,
   output logic       direction,
   output logic       duck_show,
   output logic       duck_hit,
   output logic       duck_escaped,
   output logic       is_done
);

   localparam int          CW       = $clog2(ESCAPE_FRAMES + 1);
   localparam logic [10:0] X_LIM    = 11'(X_MAX);
   localparam logic [10:0] Y_LIM    = 11'(Y_GRASS);
   localparam logic [9:0]  Y_START  = 10'(Y_GRASS);
   localparam logic [10:0] FALL_INC = 11'(FALL_SPD);
   localparam logic [4:0]  V_NOM    = 5'(NOMINAL_V_SPD);
   localparam logic [CW-1:0] ESC_CNT = CW'(ESCAPE_FRAMES);

   duck_st_e      state_q, state_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic [4:0]    v_q, v_d;
   logic          dir_q, dir_d;
   logic          up_q, up_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit_q, hit_d;
   logic          esc_q, esc_d;

   logic [10:0]   x_fwd, y_fwd, y_rise, y_fall;
   logic          x_oob, y_bounce, hit_rise;
   logic [CW-1:0] cnt_nxt;

   // 11-bit candidates: a leftward underflow wraps above 2016, so one
   // compare against X_MAX catches both the left and the right wall.
   always_comb begin
      x_fwd    = dir_q ? ({1'b0, x_q} + 11'(h_spd)) : ({1'b0, x_q} - 11'(h_spd));
      y_rise   = {1'b0, y_q} - 11'(v_q);
      y_fall   = {1'b0, y_q} + 11'(v_q);
      y_fwd    = up_q ? y_rise : y_fall;
      x_oob    = (x_fwd >= X_LIM);
      y_bounce = up_q ? y_rise[10] : (y_fall > Y_LIM);
      hit_rise = hit & ~hit_q;
      cnt_nxt  = cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      v_d     = v_q;
      dir_d   = dir_q;
      up_d    = up_q;
      cnt_d   = cnt_q;
      // Edge history tracks the raw input every cycle, so a hit already high
      // when SPAWN runs produces no edge once the duck starts flying.
      hit_d   = hit;
      esc_d   = 1'b0;

      if (game_start) begin
         state_d = ST_SPAWN;
      end else begin
         unique case (state_q)
            ST_SPAWN: begin
               x_d     = start_x;
               y_d     = Y_START;
               up_d    = 1'b1;
               dir_d   = spawn_dir;
               v_d     = (v_spd == '0) ? V_NOM : v_spd;
               cnt_d   = '0;
               state_d = ST_FLY;
            end
            ST_FLY: begin
               if (hit_rise) begin
                  state_d = ST_FALL;
               end else begin
                  if (new_frame) begin
                     if (x_oob) dir_d = ~dir_q;
                     else       x_d   = x_fwd[9:0];
                     if (y_bounce) up_d = ~up_q;
                     else          y_d  = y_fwd[9:0];
                     cnt_d = cnt_nxt;
                  end
                  if (no_ammo || (new_frame && (cnt_nxt >= ESC_CNT)))
                     state_d = ST_ESCAPE;
               end
            end
            ST_ESCAPE: begin
               if (hit_rise) begin
                  state_d = ST_FALL;
               end else if (new_frame) begin
                  if (y_rise[10]) begin
                     esc_d   = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     y_d = y_rise[9:0];
                  end
               end
            end
            ST_FALL: begin
               if (new_frame) begin
                  if (({1'b0, y_q} + FALL_INC) > Y_LIM) begin
                     y_d     = Y_START;
                     state_d = ST_DONE;
                  end else begin
                     y_d = y_q + FALL_INC[9:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         v_q     <= '0;
         dir_q   <= 1'b0;
         up_q    <= 1'b0;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         esc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         v_q     <= v_d;
         dir_q   <= dir_d;
         up_q    <= up_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         esc_q   <= esc_d;
      end
   end

   assign duck_x       = x_q;
   assign duck_y       = y_q;
   assign direction    = dir_q;
   assign duck_show    = (state_q == ST_FLY) || (state_q == ST_FALL) || (state_q == ST_ESCAPE);
   assign duck_hit     = (state_q == ST_FALL);
   assign duck_escaped = esc_q;
   assign is_done      = (state_q == ST_DONE);

endmodule

// File: rtl/ctl_duck_multi.sv
// Multi-duck controller: N_DUCKS independent channels sliced from flat buses.
// The round is done while every channel sits in DONE.
module ctl_duck_multi
   import duck_pkg::*;
#(
   parameter int N_DUCKS       = 2,
   parameter int X_MAX         = DEF_X_MAX,
   parameter int Y_GRASS       = DEF_Y_GRASS,
   parameter int NOMINAL_V_SPD = DEF_NOMINAL_V_SPD,
   parameter int FALL_SPD      = DEF_FALL_SPD,
   parameter int ESCAPE_FRAMES = DEF_ESCAPE_FRAMES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    new_frame,
   input  logic                    game_start,
   input  logic                    no_ammo,
   input  logic [N_DUCKS-1:0]      hit,
   input  logic [N_DUCKS-1:0]      spawn_dir,
   input  logic [5*N_DUCKS-1:0]    v_spd,
   input  logic [5*N_DUCKS-1:0]    h_spd,
   input  logic [10*N_DUCKS-1:0]   start_x,
   output logic [10*N_DUCKS-1:0]   duck_x,
   output logic [10*N_DUCKS-1:0]   duck_y,
   output logic [N_DUCKS-1:0]      direction,
   output logic [N_DUCKS-1:0]      duck_show,
   output logic [N_DUCKS-1:0]      duck_hit,
   output logic [N_DUCKS-1:0]      duck_escaped,
   output logic                    round_done
);

   logic [N_DUCKS-1:0] ch_done;

   for (genvar g = 0; g < N_DUCKS; g++) begin : g_ch
      ctl_duck_ch #(
         .X_MAX         (X_MAX),
         .Y_GRASS       (Y_GRASS),
         .NOMINAL_V_SPD (NOMINAL_V_SPD),
         .FALL_SPD      (FALL_SPD),
         .ESCAPE_FRAMES (ESCAPE_FRAMES)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .new_frame    (new_frame),
         .game_start   (game_start),
         .no_ammo      (no_ammo),
         .hit          (hit[g]),
         .spawn_dir    (spawn_dir[g]),
         .v_spd        (v_spd[5*g +: 5]),
         .h_spd        (h_spd[5*g +: 5]),
         .start_x      (start_x[10*g +: 10]),
         .duck_x       (duck_x[10*g +: 10]),
         .duck_y       (duck_y[10*g +: 10]),
         .direction    (direction[g]),
         .duck_show    (duck_show[g]),
         .duck_hit     (duck_hit[g]),
         .duck_escaped (duck_escaped[g]),
         .is_done      (ch_done[g])
      );
   end

   assign round_done = &ch_done;

endmodule
